// File: rtl/tmds_gearbox_10_to_2_pkg.sv
// Shared constants, types and state encoding for the 10:2 TMDS gearbox.
package tmds_gearbox_10_to_2_pkg;

    localparam int SLOTS              = 5;
    localparam int LOAD_SLOT_DEFAULT  = 2;
    localparam int LOCK_EDGES_DEFAULT = 3;
    localparam int SLOT_W             = 3;
    localparam int WORD_W             = 10;

    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [WORD_W-1:0] tmds_word_t;

    typedef enum logic {
        ALIGN  = 1'b0,
        LOCKED = 1'b1
    } gb_state_e;

    function automatic slot_t next_slot(input slot_t s);
        return (s == slot_t'(SLOTS - 1)) ? '0 : s + 1'b1;
    endfunction

endpackage

// File: rtl/tmds_gearbox_10_to_2_if.sv
// Word-side inputs and serial-side outputs of the gearbox, bundled as one port.
interface tmds_gearbox_10_to_2_if;
    import tmds_gearbox_10_to_2_pkg::*;

    logic       phase_tog;
    tmds_word_t din;
    logic       q_rise;
    logic       q_fall;
    logic       locked;
    logic [7:0] slip_count;

    modport master (
        output phase_tog, din,
        input  q_rise, q_fall, locked, slip_count
    );

    modport slave (
        input  phase_tog, din,
        output q_rise, q_fall, locked, slip_count
    );
endinterface

// File: rtl/tmds_gearbox_10_to_2_phase_tracker.sv
// Recovers the clk_x1 word phase from phase_tog and decides when the gearbox is locked.
module gearbox_phase_tracker
    import tmds_gearbox_10_to_2_pkg::*;
#(
    parameter int LOCK_EDGES = LOCK_EDGES_DEFAULT
) (
    input  logic  clk_x5,
    input  logic  reset,
    input  logic  i_phase_tog,
    output slot_t o_slot,
    output logic  o_locked,
    output logic  o_slip
);

    localparam int GOOD_W = $clog2(LOCK_EDGES + 1);

    logic              r_tog_q;
    logic              r_tog_qq;
    slot_t             r_slot;
    gb_state_e         r_state;
    logic              r_locked;
    logic [GOOD_W-1:0] r_good_cnt;
    logic              r_seen;

    logic w_edge;
    logic w_on_time;
    logic w_slip;

    // An edge is expected exactly when the previous slot was the last one.
    assign w_edge    = r_tog_q ^ r_tog_qq;
    assign w_on_time = (r_slot == slot_t'(SLOTS - 1));
    assign w_slip    = (r_state == LOCKED) && (w_edge != w_on_time);

    always_ff @(posedge clk_x5 or posedge reset) begin
        if (reset) begin
            r_tog_q    <= 1'b0;
            r_tog_qq   <= 1'b0;
            r_slot     <= '0;
            r_state    <= ALIGN;
            r_locked   <= 1'b0;
            r_good_cnt <= '0;
            r_seen     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_tog_q  <= i_phase_tog;
            r_tog_qq <= r_tog_q;
            r_slot   <= w_edge ? '0 : next_slot(r_slot);
            case (r_state)
                ALIGN: begin
                    if (r_good_cnt == GOOD_W'(LOCK_EDGES)) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                    end else if (w_edge) begin
                        if (r_seen && w_on_time) begin
                            r_good_cnt <= r_good_cnt + 1'b1;
                        end else begin
                            r_good_cnt <= '0;
                            r_seen     <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (w_slip) begin
                        r_state    <= ALIGN;
                        r_locked   <= 1'b0;
                        r_good_cnt <= '0;
                    end
                end
            endcase
        end
    end

    assign o_slot   = r_slot;
    assign o_locked = r_locked;
    // Slip stays combinational so the top can drop the word on the unlocking edge.
    assign o_slip   = w_slip;

endmodule

// File: rtl/tmds_gearbox_10_to_2.sv
// 10-bit TMDS word to 2-bit-per-clk_x5 serialiser feeding an ODDR (LSB first).
module tmds_gearbox_10_to_2
    import tmds_gearbox_10_to_2_pkg::*;
#(
    parameter int LOAD_SLOT  = LOAD_SLOT_DEFAULT,
    parameter int LOCK_EDGES = LOCK_EDGES_DEFAULT
) (
    input logic                   clk_x5,
    input logic                   reset,
    tmds_gearbox_10_to_2_if.slave bus
);

    slot_t      w_slot;
    logic       w_locked;
    logic       w_slip;
    logic       w_load;
    tmds_word_t r_shift;
    logic [7:0] r_slip_count;

    gearbox_phase_tracker #(
        .LOCK_EDGES (LOCK_EDGES)
    ) u_phase_tracker (
        .clk_x5      (clk_x5),
        .reset       (reset),
        .i_phase_tog (bus.phase_tog),
        .o_slot      (w_slot),
        .o_locked    (w_locked),
        .o_slip      (w_slip)
    );

    assign w_load = w_locked && (w_slot == slot_t'(LOAD_SLOT));

    // The low bit pair of the shift register is the output flop pair itself.
    always_ff @(posedge clk_x5 or posedge reset) begin
        if (reset) begin
            r_shift      <= '0;
            r_slip_count <= '0;
        end else begin
            if (w_slip || !w_locked) begin
                r_shift <= '0;
            end else if (w_load) begin
                r_shift <= bus.din;
            end else begin
                r_shift <= {2'b00, r_shift[WORD_W-1:2]};
            end
            if (w_slip && (r_slip_count != 8'hFF)) begin
                r_slip_count <= r_slip_count + 1'b1;
            end
        end
    end

    assign bus.q_rise     = r_shift[0];
    assign bus.q_fall     = r_shift[1];
    assign bus.locked     = w_locked;
    assign bus.slip_count = r_slip_count;

endmodule

// File: doc/tmds_gearbox_10_to_2.md
TMDS_GEARBOX_10_TO_2 -- requirements
Module: tmds_gearbox_10_to_2

Interface
REQ-001 Parameter LOAD_SLOT, default 2: slot index (0..4) at which din is captured, mid-window of the clk_x1 word period.
REQ-002 Parameter LOCK_EDGES, default 3: consecutive correctly spaced phase edges required to enter LOCKED.
REQ-003 reset  input  1  asynchronous, active-high; clock clk_x5.
REQ-004 clk_x5  input  1  bit-pair clock, 5x the word rate, phase-related to clk_x1.
REQ-005 phase_tog  input  1  toggles once per clk_x1 cycle (driven from the clk_x1 domain); sampled on clk_x5.
REQ-006 din  input  10  TMDS symbol from the clk_x1 domain, stable for each whole clk_x1 period.
REQ-007 q_rise  output  1  bit for the ODDR rising edge (even bit index).
REQ-008 q_fall  output  1  bit for the ODDR falling edge (odd bit index).
REQ-009 locked  output  1  high while the gearbox is in state LOCKED.
REQ-010 slip_count  output  8  saturating count of LOCKED->ALIGN transitions.

Function
REQ-011 The block SHALL register phase_tog twice (tog_q, tog_qq); edge = tog_q XOR tog_qq.
REQ-012 A slot counter SHALL count 0..4 and wrap 4->0; on a cycle with edge it SHALL be forced to 0 (slot 0 = edge cycle).
REQ-013 States: ALIGN (reset state) and LOCKED.
REQ-014 In ALIGN, an edge with previous slot == 4 and a prior edge already seen SHALL increment good_cnt; any other edge SHALL set good_cnt to 0 and mark the first edge as seen.
REQ-015 ALIGN->LOCKED SHALL occur on the cycle after good_cnt reaches LOCK_EDGES; locked rises in the same cycle.
REQ-016 In LOCKED, an edge while slot != 4, or no edge while slot == 4, SHALL cause LOCKED->ALIGN on the next cycle, clear good_cnt and increment slip_count (saturating at 255).
REQ-017 In LOCKED, when slot == LOAD_SLOT, the 10-bit shift register SHALL load din.
REQ-018 On each cycle after a load, q_rise/q_fall SHALL present bits [1:0], [3:2], [5:4], [7:6], [9:8] on successive cycles; the shift register shifts right by 2 per cycle.
REQ-019 Latency: din[0]/din[1] appear on q_rise/q_fall exactly 1 cycle after the load cycle; the word is LSB-first.
REQ-020 Output registers SHALL be flops driven from the shift register; no combinational path from din to outputs.
REQ-021 In ALIGN, and in LOCKED before the first load, q_rise and q_fall SHALL be 0; a word in flight when lock is lost SHALL be discarded and the outputs zeroed from the transition cycle.
REQ-022 A good edge and a load slot never coincide (LOAD_SLOT != 0); slot 4 with edge in LOCKED is the normal case and SHALL NOT count as a slip.

Reset
REQ-023 While reset is high: state = ALIGN, slot = 0, good_cnt = 0, first-edge flag = 0, tog_q = tog_qq = 0, shift register = 0, q_rise = q_fall = 0, locked = 0, slip_count = 0.
REQ-024 Reset asserted mid-word SHALL abort the word immediately; after release the block SHALL re-acquire lock from scratch.

Structure
REQ-025 The shared package SHALL hold the constants SLOTS = 5, the default LOAD_SLOT = 2, the default LOCK_EDGES = 3, and the state encoding (ALIGN, LOCKED).
REQ-026 The edge detector, slot counter and lock FSM SHALL be one sub-module, gearbox_phase_tracker, outputting slot, locked and a slip pulse; the top level holds the shift register, outputs and slip_count.

Verification
REQ-027 Clean lock: phase_tog toggling every 5 cycles from reset release -> locked rises after the 4th edge (the 3rd good edge), slip_count = 0.
REQ-028 Data order: din = 10'b1101000110 held one word period in LOCKED -> q_rise,q_fall pairs (0,1),(1,0),(0,0),(1,0),(1,1) on 5 consecutive cycles, starting 1 cycle after slot 2.
REQ-029 Early edge: in LOCKED, inject an edge at slot 3 -> locked falls next cycle, outputs 0, slip_count = 1, relock after 3 good edges.
REQ-030 Missing edge: in LOCKED, suppress one toggle -> unlock at slot 4 with no edge, slip_count increments by 1.
REQ-031 Saturation: force 300 slips -> slip_count holds at 255.
REQ-032 Reset mid-word: assert reset at slot 3 of a word -> all outputs 0 asynchronously; after release, no output before lock is re-acquired.
